// File: rtl/mcu_clk_ctrl_pkg.sv
// Shared types for the yrv_mcu clock-enable sequencer: FSM states and debug mode encodings.
// Mode value 3 is reserved and never produced by mode_of().
package mcu_clk_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_SLOW,
      ST_STEP_IDLE,
      ST_STEP_PULSE,
      ST_STEP_HOLD
   } state_t;

   localparam logic [1:0] MODE_RUN  = 2'd0;
   localparam logic [1:0] MODE_SLOW = 2'd1;
   localparam logic [1:0] MODE_STEP = 2'd2;

   function automatic logic [1:0] mode_of(input state_t s);
      case (s)
         ST_RUN:  mode_of = MODE_RUN;
         ST_SLOW: mode_of = MODE_SLOW;
         default: mode_of = MODE_STEP;
      endcase
   endfunction

endpackage

// File: rtl/mcu_clk_ctrl_key_debounce.sv
// Key conditioner: 2-flop synchronizer, stability counter, debounced level and press pulse.
// Level follows the key after 2 + DEBOUNCE_CYCLES cycles; press is a 1-cycle pulse on the 1->0 level change.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_key_n,
   output logic o_level,
   output logic o_press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_level <= 1'b1;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         // Any sample agreeing with the current level restarts the stability window.
         if (r_sync2 != r_level) begin
            if (r_cnt == CNT_LAST) begin
               r_level <= r_sync2;
               r_press <= ~r_sync2;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;

endmodule

// File: rtl/mcu_clk_ctrl.sv
// Clock-enable sequencer for yrv_mcu: RUN / periodic SLOW tick / debounced single STEP, all in the clk domain.
// Optional breakpoint-to-STEP entry is built only when MCU_CLK_CTRL_BREAK_EN is defined.
module mcu_clk_ctrl
   import mcu_clk_ctrl_pkg::*;
#(
   parameter int SLOW_DIV_W      = 23,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        key_slow_n,
   input  logic        key_mode_n,
   input  logic        key_step_n,
   input  logic [31:0] mem_addr,
   input  logic [31:0] bp_addr,
   input  logic        bp_valid,
   output logic        cpu_ce,
   output logic [1:0]  mode,
   output logic [31:0] ce_count
);

   logic w_slow_level;
   logic w_slow_press_unused;
   logic w_mode_level_unused;
   logic w_mode_press;
   logic w_step_level;
   logic w_step_press;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_slow (
      .clk     (clk),
      .reset_n (reset_n),
      .i_key_n (key_slow_n),
      .o_level (w_slow_level),
      .o_press (w_slow_press_unused)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
      .clk     (clk),
      .reset_n (reset_n),
      .i_key_n (key_mode_n),
      .o_level (w_mode_level_unused),
      .o_press (w_mode_press)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_step (
      .clk     (clk),
      .reset_n (reset_n),
      .i_key_n (key_step_n),
      .o_level (w_step_level),
      .o_press (w_step_press)
   );

   state_t                r_state;
   state_t                w_next_state;
   logic                  r_started;
   logic                  r_cpu_ce;
   logic [1:0]            r_mode;
   logic [31:0]           r_ce_count;
   logic [SLOW_DIV_W-1:0] r_div;
   logic                  w_ce_next;
   logic                  w_clr_count;

`ifdef MCU_CLK_CTRL_BREAK_EN
   logic w_bp_hit;
   assign w_bp_hit = bp_valid && r_cpu_ce && (mem_addr == bp_addr);
`else
   logic w_unused_bp;
   assign w_unused_bp = ^{mem_addr, bp_addr, bp_valid};
`endif

   always_comb begin
      w_next_state = r_state;
      w_ce_next    = 1'b0;
      w_clr_count  = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (!w_slow_level) begin
               w_next_state = ST_SLOW;
               w_clr_count  = 1'b1;
`ifdef MCU_CLK_CTRL_BREAK_EN
            end else if (w_bp_hit) begin
               w_next_state = ST_STEP_IDLE;
               w_clr_count  = 1'b1;
`endif
            end
         end
         ST_SLOW: begin
            if (w_slow_level) begin
               w_next_state = ST_RUN;
            end else if (w_mode_press) begin
               w_next_state = ST_STEP_IDLE;
            end else begin
               w_ce_next = (r_div == '1);
            end
         end
         ST_STEP_IDLE: begin
            if (w_slow_level) begin
               w_next_state = ST_RUN;
            end else if (w_step_press) begin
               w_next_state = ST_STEP_PULSE;
               w_ce_next    = 1'b1;
            end else if (w_mode_press) begin
               w_next_state = ST_SLOW;
            end
         end
         ST_STEP_PULSE: begin
            if (w_slow_level) w_next_state = ST_RUN;
            else              w_next_state = ST_STEP_HOLD;
         end
         ST_STEP_HOLD: begin
            if (w_slow_level)      w_next_state = ST_RUN;
            else if (w_step_level) w_next_state = ST_STEP_IDLE;
         end
         default: w_next_state = ST_RUN;
      endcase
      // r_started holds off the first RUN enable by one edge after reset release.
      if (w_next_state == ST_RUN) w_ce_next = r_started;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_RUN;
      else          r_state <= w_next_state;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_started  <= 1'b0;
         r_cpu_ce   <= 1'b0;
         r_mode     <= MODE_RUN;
         r_ce_count <= '0;
         r_div      <= '0;
      end else begin
         r_started <= 1'b1;
         r_cpu_ce  <= w_ce_next;
         r_mode    <= mode_of(w_next_state);
         // Divider restarts on every entry to SLOW so the first tick lands a full period later.
         if (r_state == ST_SLOW && w_next_state == ST_SLOW) r_div <= r_div + 1'b1;
         else                                               r_div <= '0;
         if (w_clr_count)                                 r_ce_count <= '0;
         else if (w_ce_next && w_next_state != ST_RUN)    r_ce_count <= r_ce_count + 32'd1;
      end
   end

   assign cpu_ce   = r_cpu_ce;
   assign mode     = r_mode;
   assign ce_count = r_ce_count;

endmodule

// File: tb/tb_mcu_clk_ctrl.sv
// Directed bench for mcu_clk_ctrl with SLOW_DIV_W=4, DEBOUNCE_CYCLES=4.
// Vector table drives key levels for N edges, then checks cpu_ce/mode/ce_count at the falling edge.
module tb_mcu_clk_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        key_slow_n;
   logic        key_mode_n;
   logic        key_step_n;
   logic [31:0] mem_addr;
   logic [31:0] bp_addr;
   logic        bp_valid;
   logic        cpu_ce;
   logic [1:0]  mode;
   logic [31:0] ce_count;

   mcu_clk_ctrl #(.SLOW_DIV_W(4), .DEBOUNCE_CYCLES(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .key_slow_n (key_slow_n),
      .key_mode_n (key_mode_n),
      .key_step_n (key_step_n),
      .mem_addr   (mem_addr),
      .bp_addr    (bp_addr),
      .bp_valid   (bp_valid),
      .cpu_ce     (cpu_ce),
      .mode       (mode),
      .ce_count   (ce_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  keys;   // {slow_n, mode_n, step_n}
      int          adv;
      logic        ce;
      logic [1:0]  md;
      logic [31:0] cnt;
   } vec_t;

   localparam int NV = 26;
   vec_t vecs[NV];

   int n_cmp = 0;
   int n_err = 0;

   function automatic vec_t mk(input logic [2:0] k, input int a, input logic c,
                               input logic [1:0] m, input logic [31:0] n);
      vec_t v;
      v.keys = k; v.adv = a; v.ce = c; v.md = m; v.cnt = n;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic chk_out(input string name, input logic c, input logic [1:0] m, input logic [31:0] n);
      chk({name, ".ce"},    0, 32'(cpu_ce), 32'(c));
      chk({name, ".mode"},  0, 32'(mode),   32'(m));
      chk({name, ".count"}, 0, ce_count,    n);
   endtask

   int          pulses;
   int          extra;
   logic [31:0] exp_cnt;

   initial begin
      // Slow entry at E = 7 edges after key_slow_n falls; ticks at E+16, E+32, E+48.
      vecs[0]  = mk(3'b011,  6, 1'b1, 2'd0, 32'd0);
      vecs[1]  = mk(3'b011,  1, 1'b0, 2'd1, 32'd0);
      vecs[2]  = mk(3'b011, 15, 1'b0, 2'd1, 32'd0);
      vecs[3]  = mk(3'b011,  1, 1'b1, 2'd1, 32'd1);
      vecs[4]  = mk(3'b011,  1, 1'b0, 2'd1, 32'd1);
      vecs[5]  = mk(3'b011, 15, 1'b1, 2'd1, 32'd2);
      vecs[6]  = mk(3'b011,  1, 1'b0, 2'd1, 32'd2);
      vecs[7]  = mk(3'b011, 15, 1'b1, 2'd1, 32'd3);
      vecs[8]  = mk(3'b011,  1, 1'b0, 2'd1, 32'd3);
      // Release slow: back to RUN, count held.
      vecs[9]  = mk(3'b111,  6, 1'b0, 2'd1, 32'd3);
      vecs[10] = mk(3'b111,  1, 1'b1, 2'd0, 32'd3);
      vecs[11] = mk(3'b111, 10, 1'b1, 2'd0, 32'd3);
      // Re-enter slow family: count cleared, then mode press before the first tick.
      vecs[12] = mk(3'b011,  7, 1'b0, 2'd1, 32'd0);
      vecs[13] = mk(3'b001,  6, 1'b0, 2'd1, 32'd0);
      vecs[14] = mk(3'b001,  1, 1'b0, 2'd2, 32'd0);
      vecs[15] = mk(3'b011,  8, 1'b0, 2'd2, 32'd0);
      // Two 10-cycle step presses, one pulse each.
      vecs[16] = mk(3'b010,  6, 1'b0, 2'd2, 32'd0);
      vecs[17] = mk(3'b010,  1, 1'b1, 2'd2, 32'd1);
      vecs[18] = mk(3'b010,  1, 1'b0, 2'd2, 32'd1);
      vecs[19] = mk(3'b010,  2, 1'b0, 2'd2, 32'd1);
      vecs[20] = mk(3'b011,  6, 1'b0, 2'd2, 32'd1);
      vecs[21] = mk(3'b011,  1, 1'b0, 2'd2, 32'd1);
      vecs[22] = mk(3'b010,  6, 1'b0, 2'd2, 32'd1);
      vecs[23] = mk(3'b010,  1, 1'b1, 2'd2, 32'd2);
      vecs[24] = mk(3'b010,  3, 1'b0, 2'd2, 32'd2);
      vecs[25] = mk(3'b011,  8, 1'b0, 2'd2, 32'd2);

      reset_n    = 1'b0;
      key_slow_n = 1'b1;
      key_mode_n = 1'b1;
      key_step_n = 1'b1;
      mem_addr   = 32'h0;
      bp_addr    = 32'h0;
      bp_valid   = 1'b0;

      tick(3);
      chk_out("reset", 1'b0, 2'd0, 32'd0);
      reset_n = 1'b1;
      tick(1);
      chk("edge1.ce", 0, 32'(cpu_ce), 32'd0);
      tick(1);
      chk_out("edge2", 1'b1, 2'd0, 32'd0);

      for (int i = 0; i < NV; i++) begin
         key_slow_n = vecs[i].keys[2];
         key_mode_n = vecs[i].keys[1];
         key_step_n = vecs[i].keys[0];
         tick(vecs[i].adv);
         chk("vec.ce",    i, 32'(cpu_ce), 32'(vecs[i].ce));
         chk("vec.mode",  i, 32'(mode),   32'(vecs[i].md));
         chk("vec.count", i, ce_count,    vecs[i].cnt);
      end

      // Step key bounce of 3 cycles in STEP_IDLE must not step.
      pulses = 0;
      key_step_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         if (cpu_ce) pulses++;
      end
      key_step_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (cpu_ce) pulses++;
      end
      chk("bounce.pulses", 0, 32'(pulses), 32'd0);
      chk_out("bounce", 1'b0, 2'd2, 32'd2);

      // Slow release and step press debounced on the same edge: RUN wins, no step pulse.
      extra = 0;
      key_slow_n = 1'b1;
      key_step_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         if (cpu_ce && mode == 2'd2) extra++;
      end
      chk("race.mode_before", 0, 32'(mode), 32'd2);
      tick(1);
      chk("race.extra", 0, 32'(extra), 32'd0);
      chk_out("race", 1'b1, 2'd0, 32'd2);
      key_step_n = 1'b1;
      tick(8);
      chk_out("race.settle", 1'b1, 2'd0, 32'd2);

      // Breakpoint match in RUN.
      bp_valid = 1'b1;
      bp_addr  = 32'h100;
      mem_addr = 32'h0FC;
      tick(1);
      chk_out("bp.nomatch", 1'b1, 2'd0, 32'd2);
      mem_addr = 32'h100;
      tick(1);
`ifdef MCU_CLK_CTRL_BREAK_EN
      chk_out("bp.hit", 1'b0, 2'd2, 32'd0);
      exp_cnt = 32'd0;
`else
      chk_out("bp.ignored", 1'b1, 2'd0, 32'd2);
      exp_cnt = 32'd2;
`endif
      bp_valid = 1'b0;
      tick(2);
      chk_out("bp.after", 1'b1, 2'd0, exp_cnt);

      // Asynchronous reset while cpu_ce is high.
      reset_n = 1'b0;
      #1;
      chk_out("async_reset", 1'b0, 2'd0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
